sseg_scan_driver: RTL

//  Parametrised multiplexed 7-segment driver: accepts a binary value on a load strobe, converts it
//  to BCD sequentially (shift-add-3), commits the digits to a shadow register, and time-multiplexes
//  N_DIGITS common anodes from one clk domain. Adds leading-zero blanking, per-digit decimal

---
 rtl/sseg_pkg.sv | 45 ++++
 rtl/bin2bcd_seq.sv | 79 +++++++
 rtl/sseg_scan_driver.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// active-low segment patterns, the converter FSM encoding and the
// BCD-digit to segment lookup.
package sseg_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // Non-decimal codes (10..15) render as a dark digit.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// A start in IDLE captures bin; BIN_W shift cycles follow, then a single
// COMMIT cycle in which valid is high and bcd holds the final digits.
// Digits beyond N_DIGITS are silently dropped; the caller flags overflow.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*N_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [BIN_W-1:0] bin_sh_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-1:0] bcd_adj;
    logic             last_shift;

    // Add-3 correction on every digit that would exceed 9 after doubling.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign last_shift = (cnt_reg == CNT_W'(BIN_W - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic: IDLE -> SHIFT (BIN_W cycles) -> COMMIT -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_SHIFT;
            ST_SHIFT:  if (last_shift) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on start, then shift one binary bit into the BCD register per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            bin_sh_reg <= '0;
            bcd_reg    <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            cnt_reg    <= '0;
            bin_sh_reg <= bin;
            bcd_reg    <= '0;
        end else if (state_reg == ST_SHIFT) begin
            bcd_reg    <= {bcd_adj[BCD_W-2:0], bin_sh_reg[BIN_W-1]};
            bin_sh_reg <= bin_sh_reg << 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end

    assign busy  = (state_reg != ST_IDLE);
    assign valid = (state_reg == ST_COMMIT);
    assign bcd   = bcd_reg;

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed common-anode 7-segment driver. Converts a loaded binary value
// to BCD in the background, commits it to a shadow register in one cycle and
// scans the digits continuously with registered pin outputs.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 65536,
    parameter int BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIN_W-1:0]    bin,
    input  logic                load,
    input  logic [N_DIGITS-1:0] dp,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          sseg,
    output logic                dp_out
);

    localparam int          BCD_W   = 4 * N_DIGITS;
    localparam int          IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int          CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [63:0] MAX_VAL = 64'(10 ** N_DIGITS - 1);

    logic                conv_busy, conv_valid;
    logic [BCD_W-1:0]    conv_bcd;
    logic                accept;
    logic                ovf_pend_reg, ovf_reg, done_reg;
    logic [BCD_W-1:0]    shadow_reg;
    logic [CNT_W-1:0]    refresh_cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [N_DIGITS-1:0] an_reg, an_next, zero_from;
    logic [6:0]          sseg_reg, sseg_next;
    logic                dp_out_reg, dp_out_next;
    logic [3:0]          cur_digit;

    assign accept = load && !conv_busy;

    bin2bcd_seq #(
        .BIN_W    (BIN_W),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .bin   (bin),
        .busy  (conv_busy),
        .valid (conv_valid),
        .bcd   (conv_bcd)
    );

    // Overflow is decided at capture time and only becomes visible with the commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_pend_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            done_reg     <= 1'b0;
            shadow_reg   <= '0;
        end else begin
            if (accept) ovf_pend_reg <= (64'(bin) > MAX_VAL);
            done_reg <= conv_valid;
            if (conv_valid) begin
                shadow_reg <= conv_bcd;
                ovf_reg    <= ovf_pend_reg;
            end
        end
    end

    // Refresh prescaler and scan index; both are clock enables in the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt_reg <= '0;
            idx_reg         <= '0;
        end else if (refresh_cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt_reg <= '0;
            idx_reg <= (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + CNT_W'(1);
        end
    end

    // zero_from[i]: digit i and every digit above it are zero.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
            assign zero_from[gi] = ~|shadow_reg[BCD_W-1:4*gi];
        end
    endgenerate

    assign cur_digit = shadow_reg[{idx_reg, 2'b00} +: 4];

    // Pin values for the currently selected digit: dash on overflow, else blanking, else decode.
    always_comb begin
        an_next          = '1;
        an_next[idx_reg] = 1'b0;
        dp_out_next      = ~dp[idx_reg];
        sseg_next        = bcd_to_seg(cur_digit);
        if (ovf_reg)
            sseg_next = SEG_DASH;
        else if (BLANK_LZ != 0 && idx_reg != '0 && zero_from[idx_reg])
            sseg_next = SEG_BLANK;
    end

    // Output registers: one cycle from index change to the pins, all dark in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_reg     <= '1;
            sseg_reg   <= SEG_BLANK;
            dp_out_reg <= 1'b1;
        end else begin
            an_reg     <= an_next;
            sseg_reg   <= sseg_next;
            dp_out_reg <= dp_out_next;
        end
    end

    assign busy   = conv_busy;
    assign done   = done_reg;
    assign ovf    = ovf_reg;
    assign an     = an_reg;
    assign sseg   = sseg_reg;
    assign dp_out = dp_out_reg;

endmodule
